// File: rtl/booth_r4_mult_seq_if.sv
// Operand/product handshake bundle for the sequential radix-4 Booth multiplier.
interface booth_r4_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sgn;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_p;
    logic                   busy;

    // Producer/consumer side: drives operands, accepts products
    modport master (
        output in_valid, in_sgn, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    // Multiplier side
    modport slave (
        input  in_valid, in_sgn, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );
endinterface

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, 2*WIDTH-bit
// product returned over a valid/ready handshake. Signed or unsigned per op.
module booth_r4_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    booth_r4_mult_seq_if.slave  bus
);
    // Digit count includes the 2-bit extension that makes unsigned mode exact
    localparam int unsigned NDIG = WIDTH / 2 + 1;
    localparam int unsigned EW   = WIDTH + 2;
    localparam int unsigned AW   = 2 * WIDTH + 2;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_m;        // multiplicand, pre-shifted by 2i for the current digit
    logic [EW:0]     r_b;        // {extended multiplier, b[-1]=0}, shifted down 2 per digit
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_out_p;
    logic            r_out_valid;
    logic            r_in_ready;
    logic            r_busy;

    logic [EW-1:0]   w_a_ext;
    logic [EW-1:0]   w_b_ext;
    logic [AW-1:0]   w_m2;
    logic [AW-1:0]   w_term;
    logic [AW-1:0]   w_acc_nxt;
    logic            w_accept;
    logic            w_last;

    // Operand extension to WIDTH+2 bits: sign or zero depending on mode
    assign w_a_ext = bus.in_sgn ? {{2{bus.in_a[WIDTH-1]}}, bus.in_a} : {2'b00, bus.in_a};
    assign w_b_ext = bus.in_sgn ? {{2{bus.in_b[WIDTH-1]}}, bus.in_b} : {2'b00, bus.in_b};

    assign w_accept  = bus.in_valid & r_in_ready & (r_state == IDLE);
    assign w_last    = (r_cnt == CW'(NDIG - 1));
    assign w_m2      = {r_m[AW-2:0], 1'b0};
    assign w_acc_nxt = r_acc + w_term;

    // Booth recoding of the current digit window {b[2i+1], b[2i], b[2i-1]}
    always_comb begin
        w_term = '0;
        case (r_b[2:0])
            3'b001, 3'b010: w_term = r_m;
            3'b011:         w_term = w_m2;
            3'b100:         w_term = -w_m2;
            3'b101, 3'b110: w_term = -r_m;
            default:        w_term = '0;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_m         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_p     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_m        <= {{WIDTH{w_a_ext[EW-1]}}, w_a_ext};
                        r_b        <= {w_b_ext, 1'b0};
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end

                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_m   <= r_m << 2;
                    r_b   <= r_b >> 2;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_out_p     <= w_acc_nxt[PW-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end

                DONE: begin
                    // in_ready only rises after this edge, so no accept here
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_p     = r_out_p;
    assign bus.busy      = r_busy;

endmodule

// File: doc/booth_r4_mult_seq.md
Name: booth_r4_mult_seq

Overview:
- Parametrised sequential radix-4 Booth multiplier: successor to the single-step Booth partial-product unit.
- Accepts a full WIDTH-bit multiplicand/multiplier pair with a per-operation signed/unsigned mode.
- Iterates one Booth digit per clock internally and returns a 2*WIDTH-bit product over a valid/ready handshake.
- Sits in the arithmetic datapath wherever an area-cheap multi-cycle multiply is acceptable.

Parameters:
- WIDTH, 8, operand width; even, >= 4.
- NDIG, WIDTH/2+1, derived localparam, not overridable: number of Booth digits/iterations, covering a 2-bit extension for unsigned mode.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_sgn  input  1  1 = both operands two's complement; 0 = both unsigned.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_p  output  2*WIDTH  product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, out_p=0, accumulator/counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: register in_a, in_b, in_sgn; clear accumulator; digit counter=0; go to CALC.
  - Operand inputs are don't-care after the accept edge.
- Operand extension to WIDTH+2 bits: sign-extend if in_sgn=1, zero-extend if in_sgn=0. Multiplicand M is then sign-extended to 2*WIDTH+2 bits for accumulation.
- CALC, one digit per cycle:
  - Digit i uses extended multiplier bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Recoding: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Term is shifted left 2i and added into the accumulator, modulo 2^(2*WIDTH+2).
  - Counter increments each cycle.
  - On the edge processing digit NDIG-1: load out_p with accumulator[2*WIDTH-1:0] including the final term; out_valid=1; go to DONE.
- Latency: exactly NDIG clock edges from the accept edge to out_valid high (WIDTH=8 -> 5).
- DONE:
  - out_valid=1; out_p stable until handshake.
  - out_valid&out_ready at an edge: out_valid=0, go to IDLE.
  - No new accept on that same edge: in_ready is registered from state and low in DONE, so back-to-back throughput is one op per NDIG+2 cycles.
- in_ready=0 and busy=1 throughout CALC and DONE; in_valid is ignored there.
- out_ready is ignored outside DONE. out_p holds its last product in IDLE (cleared only by reset).
- Asynchronous reset mid-CALC or mid-DONE: immediate return to reset values; the partial result is discarded and no out_valid is produced.
- Arithmetic is exact for all operand pairs in both modes, including signed -2^(WIDTH-1) * -2^(WIDTH-1) and unsigned (2^WIDTH-1)^2. No overflow flag.

Test Plan:
- WIDTH=8, signed, a=7, b=-63 (0xC1), out_ready=1: in_ready drops the cycle after accept; out_valid rises exactly 5 edges after accept; out_p=0xFE47 (-441); returns to IDLE the next edge.
- WIDTH=8, unsigned, a=0xFF, b=0xFF -> out_p=0xFE01. Same operands with sgn=1 -> out_p=0x0001.
- WIDTH=8, signed, corner pairs:
  - -128 * -128 -> 0x4000.
  - -128 * 127 -> 0xC080.
  - 0 * -1 -> 0x0000.
  - Randomised 1000 pairs in each mode against a reference model.
- Backpressure: out_ready held low 6 cycles after out_valid -> out_valid and out_p stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> one handshake, then in_ready=1 on the following cycle.
- Reset mid-operation: assert rst_n=0 on the 3rd CALC cycle -> out_valid/busy low and in_ready high immediately. A subsequent op (5*6 unsigned) yields 0x001E with normal latency.
- WIDTH=16 instance, signed, 0x7FFF * 0x8000 -> out_p=0xC0008000; out_valid after 9 edges.
